// File: rtl/pipe_stage_reg_pkg.sv
// Shared definitions for the configurable inter-stage pipeline register:
// write-data select codes and the default link-address offset.
package pipe_stage_reg_pkg;

    typedef enum logic [1:0] {
        WDSEL_DR = 2'd0,
        WDSEL_AO = 2'd1,
        WDSEL_PC = 2'd2,
        WDSEL_MD = 2'd3
    } wdsel_e;

    localparam int PC_OFS_DEFAULT = 8;

endpackage

// File: rtl/pipe_stage_reg_sat_dec.sv
// Saturating decrementer: y = max(a - 1, 0), never wraps below zero.
module pipe_stage_reg_sat_dec #(
    parameter int TW = 3
) (
    input  logic [TW-1:0] a,
    output logic [TW-1:0] y
);

    always_comb begin
        y = '0;
        if (a != '0) begin
            y = a - 1'b1;
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// Parametrised MIPS inter-stage register with stall/flush, valid tracking,
// Tnew ageing, forwarding-ready flag and a saturating bubble counter.
module pipe_stage_reg
    import pipe_stage_reg_pkg::*;
#(
    parameter int DW        = 32,
    parameter int AW        = 5,
    parameter int TW        = 3,
    parameter int PC_OFS    = PC_OFS_DEFAULT,
    parameter int HOLD_AGES = 1,
    parameter int CW        = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          stall,
    input  logic          flush,
    input  logic          in_valid,
    input  logic [DW-1:0] IR,
    input  logic [DW-1:0] PC,
    input  logic [DW-1:0] DR,
    input  logic [DW-1:0] AO,
    input  logic [DW-1:0] MD,
    input  logic [AW-1:0] A3,
    input  logic [TW-1:0] Tnew,
    input  logic [1:0]    WDSel,
    output logic          valid_o,
    output logic [DW-1:0] IR_o,
    output logic [DW-1:0] PC_o,
    output logic [DW-1:0] DR_o,
    output logic [DW-1:0] AO_o,
    output logic [AW-1:0] A3_o,
    output logic [TW-1:0] Tnew_o,
    output logic [DW-1:0] WD_o,
    output logic          fwd_en,
    output logic [CW-1:0] bubble_cnt
);

    logic          valid_q, valid_d;
    logic [DW-1:0] ir_q, ir_d;
    logic [DW-1:0] pc_q, pc_d;
    logic [DW-1:0] dr_q, dr_d;
    logic [DW-1:0] ao_q, ao_d;
    logic [AW-1:0] a3_q, a3_d;
    logic [TW-1:0] tnew_q, tnew_d;
    logic [DW-1:0] wd_q, wd_d;
    logic [CW-1:0] bubble_q, bubble_d;

    logic [TW-1:0] tnew_load;
    logic [TW-1:0] tnew_aged;
    logic [DW-1:0] wd_sel;

    pipe_stage_reg_sat_dec #(.TW(TW)) u_dec_load (
        .a (Tnew),
        .y (tnew_load)
    );

    pipe_stage_reg_sat_dec #(.TW(TW)) u_dec_hold (
        .a (tnew_q),
        .y (tnew_aged)
    );

    always_comb begin
        wd_sel = DR;
        case (wdsel_e'(WDSel))
            WDSEL_DR: wd_sel = DR;
            WDSEL_AO: wd_sel = AO;
            WDSEL_PC: wd_sel = PC + DW'(PC_OFS);
            WDSEL_MD: wd_sel = MD;
            default:  wd_sel = DR;
        endcase
    end

    // A load with in_valid low is treated exactly like a flush (bubble).
    always_comb begin
        valid_d  = valid_q;
        ir_d     = ir_q;
        pc_d     = pc_q;
        dr_d     = dr_q;
        ao_d     = ao_q;
        a3_d     = a3_q;
        tnew_d   = tnew_q;
        wd_d     = wd_q;
        bubble_d = bubble_q;

        if (flush || (!stall && !in_valid)) begin
            valid_d = 1'b0;
            ir_d    = '0;
            pc_d    = '0;
            dr_d    = '0;
            ao_d    = '0;
            a3_d    = '0;
            tnew_d  = '0;
            wd_d    = '0;
        end else if (stall) begin
            if (HOLD_AGES != 0) begin
                tnew_d = tnew_aged;
            end
        end else begin
            valid_d = 1'b1;
            ir_d    = IR;
            pc_d    = PC;
            dr_d    = DR;
            ao_d    = AO;
            a3_d    = A3;
            tnew_d  = tnew_load;
            wd_d    = wd_sel;
        end

        if (!valid_d && (bubble_q != {CW{1'b1}})) begin
            bubble_d = bubble_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q  <= 1'b0;
            ir_q     <= '0;
            pc_q     <= '0;
            dr_q     <= '0;
            ao_q     <= '0;
            a3_q     <= '0;
            tnew_q   <= '0;
            wd_q     <= '0;
            bubble_q <= '0;
        end else begin
            valid_q  <= valid_d;
            ir_q     <= ir_d;
            pc_q     <= pc_d;
            dr_q     <= dr_d;
            ao_q     <= ao_d;
            a3_q     <= a3_d;
            tnew_q   <= tnew_d;
            wd_q     <= wd_d;
            bubble_q <= bubble_d;
        end
    end

    assign valid_o    = valid_q;
    assign IR_o       = ir_q;
    assign PC_o       = pc_q;
    assign DR_o       = dr_q;
    assign AO_o       = ao_q;
    assign A3_o       = a3_q;
    assign Tnew_o     = tnew_q;
    assign WD_o       = wd_q;
    assign bubble_cnt = bubble_q;
    assign fwd_en     = valid_q && (a3_q != '0) && (tnew_q == '0);

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench: two instances (ageing with 4-bit counter, frozen Tnew with
// 16-bit counter) share stimulus and are checked against a behavioural model.
module tb_pipe_stage_reg;

    logic        clk = 1'b0;
    logic        rst, stall, flush, in_valid;
    logic [31:0] IR, PC, DR, AO, MD;
    logic [4:0]  A3;
    logic [2:0]  Tnew;
    logic [1:0]  WDSel;

    logic        a_valid, b_valid, a_fwd, b_fwd;
    logic [31:0] a_ir, a_pc, a_dr, a_ao, a_wd, b_ir, b_pc, b_dr, b_ao, b_wd;
    logic [4:0]  a_a3, b_a3;
    logic [2:0]  a_tnew, b_tnew;
    logic [3:0]  a_bub;
    logic [15:0] b_bub;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipe_stage_reg #(.DW(32), .AW(5), .TW(3), .PC_OFS(8), .HOLD_AGES(1), .CW(4)) dut_a (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .in_valid(in_valid),
        .IR(IR), .PC(PC), .DR(DR), .AO(AO), .MD(MD), .A3(A3), .Tnew(Tnew), .WDSel(WDSel),
        .valid_o(a_valid), .IR_o(a_ir), .PC_o(a_pc), .DR_o(a_dr), .AO_o(a_ao),
        .A3_o(a_a3), .Tnew_o(a_tnew), .WD_o(a_wd), .fwd_en(a_fwd), .bubble_cnt(a_bub)
    );

    pipe_stage_reg #(.DW(32), .AW(5), .TW(3), .PC_OFS(8), .HOLD_AGES(0), .CW(16)) dut_b (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .in_valid(in_valid),
        .IR(IR), .PC(PC), .DR(DR), .AO(AO), .MD(MD), .A3(A3), .Tnew(Tnew), .WDSel(WDSel),
        .valid_o(b_valid), .IR_o(b_ir), .PC_o(b_pc), .DR_o(b_dr), .AO_o(b_ao),
        .A3_o(b_a3), .Tnew_o(b_tnew), .WD_o(b_wd), .fwd_en(b_fwd), .bubble_cnt(b_bub)
    );

    typedef struct {
        bit          valid;
        logic [31:0] ir, pc, dr, ao, wd;
        int          a3;
        int          tnew_a, tnew_b;
        int          bub_a, bub_b;
    } exp_t;

    exp_t sb[$];
    exp_t m;

    function automatic int decSat(input int t);
        return (t > 0) ? t - 1 : 0;
    endfunction

    function automatic bit fwdOf(input bit v, input int a3, input int t);
        return v && (a3 != 0) && (t == 0);
    endfunction

    // Behavioural model: rst > flush > stall > load; a non-valid load is a bubble.
    task automatic modelStep();
        exp_t n;
        n = m;
        if (rst) begin
            n = '{default: 0};
        end else begin
            if (flush || (!stall && !in_valid)) begin
                n.valid = 0; n.ir = 0; n.pc = 0; n.dr = 0; n.ao = 0; n.wd = 0;
                n.a3 = 0; n.tnew_a = 0; n.tnew_b = 0;
            end else if (stall) begin
                n.tnew_a = decSat(m.tnew_a);
            end else begin
                n.valid = 1; n.ir = IR; n.pc = PC; n.dr = DR; n.ao = AO;
                n.a3 = int'(A3);
                n.tnew_a = decSat(int'(Tnew));
                n.tnew_b = n.tnew_a;
                case (WDSel)
                    2'd0: n.wd = DR;
                    2'd1: n.wd = AO;
                    2'd2: n.wd = PC + 32'd8;
                    default: n.wd = MD;
                endcase
            end
            if (!n.valid) begin
                if (n.bub_a < 15) n.bub_a = n.bub_a + 1;
                if (n.bub_b < 65535) n.bub_b = n.bub_b + 1;
            end
        end
        m = n;
        sb.push_back(n);
    endtask

    task automatic applyStimulus(input bit r, input bit s, input bit f, input bit v,
                                 input logic [31:0] ir, input logic [31:0] pc,
                                 input logic [31:0] dr, input logic [31:0] ao,
                                 input logic [31:0] md, input logic [4:0] a3,
                                 input logic [2:0] tn, input logic [1:0] sel);
        @(negedge clk);
        rst = r; stall = s; flush = f; in_valid = v;
        IR = ir; PC = pc; DR = dr; AO = ao; MD = md; A3 = a3; Tnew = tn; WDSel = sel;
        modelStep();
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
        end
    endtask

    // Monitor: every edge presents a new register state, compared with the oldest entry.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                checkOutput("a_valid", 32'(a_valid), 32'(e.valid));
                checkOutput("a_ir",    a_ir, e.ir);
                checkOutput("a_pc",    a_pc, e.pc);
                checkOutput("a_dr",    a_dr, e.dr);
                checkOutput("a_ao",    a_ao, e.ao);
                checkOutput("a_wd",    a_wd, e.wd);
                checkOutput("a_a3",    32'(a_a3), 32'(e.a3));
                checkOutput("a_tnew",  32'(a_tnew), 32'(e.tnew_a));
                checkOutput("a_fwd",   32'(a_fwd), 32'(fwdOf(e.valid, e.a3, e.tnew_a)));
                checkOutput("a_bub",   32'(a_bub), 32'(e.bub_a));
                checkOutput("b_valid", 32'(b_valid), 32'(e.valid));
                checkOutput("b_ir",    b_ir, e.ir);
                checkOutput("b_pc",    b_pc, e.pc);
                checkOutput("b_dr",    b_dr, e.dr);
                checkOutput("b_ao",    b_ao, e.ao);
                checkOutput("b_wd",    b_wd, e.wd);
                checkOutput("b_a3",    32'(b_a3), 32'(e.a3));
                checkOutput("b_tnew",  32'(b_tnew), 32'(e.tnew_b));
                checkOutput("b_fwd",   32'(b_fwd), 32'(fwdOf(e.valid, e.a3, e.tnew_b)));
                checkOutput("b_bub",   32'(b_bub), 32'(e.bub_b));
            end
        end
    end

    initial begin
        int budget;
        m = '{default: 0};
        rst = 1; stall = 0; flush = 0; in_valid = 0;
        IR = 0; PC = 0; DR = 0; AO = 0; MD = 0; A3 = 0; Tnew = 0; WDSel = 0;

        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk); #2;
        checkOutput("reset_valid", 32'(a_valid), 0);
        checkOutput("reset_bub", 32'(a_bub), 0);

        applyStimulus(0, 0, 0, 1, 32'h012A4020, 32'h3000, 32'h11, 32'h22, 32'h33, 5'd31, 3'd2, 2'd2);
        @(posedge clk); #2;
        checkOutput("load_pc", a_pc, 32'h3000);
        checkOutput("load_wd", a_wd, 32'h3008);
        checkOutput("load_tnew", 32'(a_tnew), 1);
        checkOutput("load_fwd", 32'(a_fwd), 0);

        applyStimulus(0, 1, 0, 1, 32'hDEAD, 32'hBEEF, 0, 0, 0, 5'd7, 3'd5, 2'd1);
        @(posedge clk); #2;
        checkOutput("stall1_tnew_a", 32'(a_tnew), 0);
        checkOutput("stall1_fwd_a", 32'(a_fwd), 1);
        checkOutput("stall1_tnew_b", 32'(b_tnew), 1);
        checkOutput("stall1_fwd_b", 32'(b_fwd), 0);
        applyStimulus(0, 1, 0, 1, 32'hDEAD, 32'hBEEF, 0, 0, 0, 5'd7, 3'd5, 2'd1);
        @(posedge clk); #2;
        checkOutput("stall2_tnew_a", 32'(a_tnew), 0);
        checkOutput("stall2_wd", a_wd, 32'h3008);

        applyStimulus(0, 1, 1, 1, 32'h1, 32'h2, 32'h3, 32'h4, 32'h5, 5'd9, 3'd1, 2'd0);
        @(posedge clk); #2;
        checkOutput("flush_valid", 32'(a_valid), 0);
        checkOutput("flush_a3", 32'(a_a3), 0);

        applyStimulus(0, 0, 0, 1, 32'h7, 32'h8, 32'h9, 32'hA, 32'hB, 5'd0, 3'd0, 2'd3);
        @(posedge clk); #2;
        checkOutput("tnew0_nowrap", 32'(a_tnew), 0);
        checkOutput("a3zero_fwd", 32'(a_fwd), 0);

        for (int i = 0; i < 20; i++) begin
            applyStimulus(0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        end
        @(posedge clk); #2;
        checkOutput("bub_saturate", 32'(a_bub), 15);

        applyStimulus(0, 0, 0, 1, 32'hCAFE, 32'h4000, 32'h1, 32'h2, 32'h3, 5'd4, 3'd3, 2'd1);
        applyStimulus(1, 1, 0, 1, 32'hCAFE, 32'h4000, 32'h1, 32'h2, 32'h3, 5'd4, 3'd3, 2'd1);
        @(posedge clk); #2;
        checkOutput("rst_stall_valid", 32'(a_valid), 0);
        checkOutput("rst_stall_wd", a_wd, 0);
        checkOutput("rst_stall_bub", 32'(a_bub), 0);

        for (int i = 0; i < 400; i++) begin
            applyStimulus(($urandom_range(0, 49) == 0),
                          ($urandom_range(0, 3) == 0),
                          ($urandom_range(0, 9) == 0),
                          ($urandom_range(0, 4) != 0),
                          $urandom, $urandom, $urandom, $urandom, $urandom,
                          ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
                          3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)));
        end

        budget = 10;
        while (sb.size() > 0 && budget > 0) begin
            @(posedge clk);
            budget--;
        end
        #2;
        if (sb.size() > 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL drain: %0d entries left, expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Parametrised inter-stage pipeline register for the five-stage MIPS core. It replaces the fixed per-stage registers (E, M, W) with one configurable block.
- It latches the instruction payload: IR, PC, DR, AO and MD. It also latches the hazard-tracking fields A3 and Tnew, and pre-selects write-back data.
- It adds behaviour the fixed registers lack:
  - stall (hold) and flush (bubble insertion), with defined priority;
  - a valid bit per stage;
  - ageing of Tnew while held;
  - a forwarding-ready output;
  - a saturating bubble counter for performance monitoring.

Parameters:
- DW, 32, data/instruction word width.
- AW, 5, register-address width (A3).
- TW, 3, Tnew field width.
- PC_OFS, 8, constant added to PC when WDSel selects PC (link address).
- HOLD_AGES, 1:
  - 1 = Tnew keeps decrementing while the stage is stalled;
  - 0 = Tnew is frozen on stall.
- CW, 16, bubble-counter width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous active-high reset.
- stall  in  1  hold current contents.
- flush  in  1  load a bubble.
- in_valid  in  1  incoming instruction is real.
- IR  in  DW  instruction.
- PC  in  DW  instruction address.
- DR  in  DW  memory read data.
- AO  in  DW  ALU result.
- MD  in  DW  HI/LO read data.
- A3  in  AW  destination register.
- Tnew  in  TW  cycles until the result is ready, as seen by the upstream stage.
- WDSel  in  2  write-data select, using shared codes DR/AO/PC/MD.
- valid_o  out  1  stage holds a real instruction.
- IR_o, PC_o, DR_o, AO_o  out  DW  latched payload.
- A3_o  out  AW  latched destination (0 when invalid).
- Tnew_o  out  TW  aged Tnew.
- WD_o  out  DW  pre-selected write data.
- fwd_en  out  1  WD_o may be forwarded to A3_o.
- bubble_cnt  out  CW  count of cycles with valid_o=0.

Behaviour:
- Single clock clk; reset rst is synchronous, active-high. All state updates occur only on the rising edge of clk.
- Reset: every registered output is 0, including valid_o, all payloads, A3_o, Tnew_o, WD_o and bubble_cnt. fwd_en is 0 as a consequence.
- Priority per edge is rst > flush > stall > load.
- flush: loads a bubble. All payload fields, A3_o, Tnew_o and WD_o become 0; valid_o becomes 0. Flush overrides a simultaneous stall.
- stall (with no flush): payload, A3_o, WD_o and valid_o hold.
  - If HOLD_AGES=1, Tnew_o becomes max(Tnew_o-1, 0).
  - If HOLD_AGES=0, Tnew_o holds.
- load (no rst, no flush, no stall):
  - payload fields, A3_o and valid_o take their inputs;
  - Tnew_o takes max(Tnew-1, 0), saturating at 0 with no wrap;
  - WD_o takes DR if WDSel=DR, AO if AO, PC+PC_OFS if PC (modulo 2^DW), MD if MD.
- When in_valid=0 on load: the register behaves as a flush. All fields are 0 and valid_o is 0.
- Latency: exactly 1 cycle from inputs to outputs on load.
- fwd_en is combinational: valid_o & (A3_o != 0) & (Tnew_o == 0). Register 0 is never forwarded.
- bubble_cnt increments by 1 on each edge, excluding reset, at which the post-edge valid_o is 0. It saturates at 2^CW-1 with no wrap.
- Reset mid-stall or mid-flush: reset wins and all outputs return to 0 on that edge.
- All four WDSel codes are legal, so there is no unreachable mux branch.

Decomposition:
- Shared header const.v holds:
  - WDSel codes (`DR=2'd0`, `AO=2'd1`, `PC=2'd2`, `MD=2'd3`);
  - the default PC_OFS.
- One natural sub-module, sat_dec, a TW-bit saturating decrementer. It is reused for the load path and the stall-ageing path.
- The WD mux stays inline.

Test Plan:
1. Reset → all outputs 0, bubble_cnt=0.
2. Load with IR=0x012A4020, PC=0x3000, WDSel=PC, A3=31, Tnew=2 → next cycle:
   - PC_o=0x3000, WD_o=0x3008, A3_o=31, Tnew_o=1, valid_o=1, fwd_en=0.
3. Hold stall=1 for 2 cycles after scenario 2 (HOLD_AGES=1) → Tnew_o goes 1→0 (then stays 0), WD_o stays 0x3008, fwd_en=1 from the first stall cycle.
   - With HOLD_AGES=0, Tnew_o stays 1 and fwd_en stays 0.
4. Assert stall=1 and flush=1 together on a valid stage → next cycle: valid_o=0, all payloads 0, A3_o=0, bubble_cnt increments by 1.
5. Drive Tnew=0 with in_valid=1 and A3=0 → Tnew_o=0 (no wrap to 7), fwd_en=0 because A3_o=0.
6. With CW=4, hold flush for 20 cycles → bubble_cnt stops at 15.
   - Then assert rst during a stall → all outputs 0 on the next edge.
